// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, 33-cycle latency.
// Optional macro MULDIV_FAST_SPECIAL_EN finishes divide-by-zero and signed overflow in one cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Handshake: start is sampled on a rising edge only when busy=0 (IDLE or DONE);
  // done is a one-cycle pulse and result holds until the next completed operation.
  state_t              state;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     a_q;
  logic [2*XLEN-1:0]   acc;
  logic [2*XLEN-1:0]   mcand;
  logic [XLEN-1:0]     work;
  logic [5:0]          cnt;
  logic                neg_q;
  logic                neg_r;
  logic                div0_q;

  logic                signed_a;
  logic                signed_b;
  logic                neg_a;
  logic                neg_b;
  logic [XLEN-1:0]     mag_a;
  logic [XLEN-1:0]     mag_b;
  logic                div0_in;
  logic [2*XLEN-1:0]   mul_sum;
  logic [XLEN:0]       div_trial;
  logic                borrow;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo;
  logic [XLEN-1:0]     remv;
  logic [XLEN-1:0]     fin;

  always_comb begin
    signed_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    signed_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    neg_a    = signed_a & a[XLEN-1];
    neg_b    = signed_b & b[XLEN-1];
    mag_a    = neg_a ? -a : a;
    mag_b    = neg_b ? -b : b;
    div0_in  = op[2] && (b == '0);
  end

`ifdef MULDIV_FAST_SPECIAL_EN
  logic            ovf_in;
  logic [XLEN-1:0] special_res;

  always_comb begin
    ovf_in      = op[2] && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special_res = '0;
    if (div0_in) special_res = op[1] ? a : '1;
    else         special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end
`endif

  // Multiply adds the shifted multiplicand per multiplier bit; divide keeps the
  // partial remainder in acc low half and shifts quotient bits into work.
  always_comb begin
    mul_sum   = acc + (work[0] ? mcand : '0);
    div_trial = {acc[XLEN-1:0], work[XLEN-1]} - {1'b0, mcand[XLEN-1:0]};
    borrow    = div_trial[XLEN];
    prod      = neg_q ? -acc : acc;
    quo       = neg_q ? -work : work;
    remv      = neg_r ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    fin       = '0;
    case (op_q)
      3'b000:                 fin = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin = div0_q ? '1 : quo;
      default:                fin = div0_q ? a_q : remv;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      op_q   <= '0;
      a_q    <= '0;
      acc    <= '0;
      mcand  <= '0;
      work   <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_q   <= op;
            a_q    <= a;
            neg_q  <= neg_a ^ neg_b;
            neg_r  <= neg_a;
            div0_q <= div0_in;
            acc    <= '0;
            cnt    <= '0;
            if (op[2]) begin
              work  <= mag_a;
              mcand <= {{XLEN{1'b0}}, mag_b};
            end else begin
              work  <= mag_b;
              mcand <= {{XLEN{1'b0}}, mag_a};
            end
`ifdef MULDIV_FAST_SPECIAL_EN
            if (div0_in || ovf_in) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
`else
            busy  <= 1'b1;
            state <= CALC;
`endif
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          // cnt==32 marks the extra cycle that applies the sign fix.
          if (cnt == 6'd32) begin
            result <= fin;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 6'd1;
            if (op_q[2]) begin
              work <= {work[XLEN-2:0], ~borrow};
              acc[XLEN-1:0] <= borrow ? {acc[XLEN-2:0], work[XLEN-1]} : div_trial[XLEN-1:0];
            end else begin
              acc   <= mul_sum;
              mcand <= mcand << 1;
              work  <= work >> 1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
